muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  EX-stage iterative multiply/divide unit owning architectural HI/LO for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
//  Fed by ID/EX pipeline register outputs; hi/lo feed the EX result mux ahead of the EX/MEM register.
//  Multi-cycle: raises stall to the hazard logic so the front of the pipe freezes while a dependent op waits.
// PARAMETERS
//  WIDTH  32  operand and HI/LO width; iteration count = WIDTH
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      synchronous, active-high reset
//  start   in   1      begin op this cycle (valid MULT/DIV in EX)
//  op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_val  in   WIDTH  multiplicand/dividend; source for MTHI/MTLO
//  rt_val  in   WIDTH  multiplier/divisor
//  mthi    in   1      write HI <= rs_val
//  mtlo    in   1      write LO <= rs_val
//  mf_req  in   1      MFHI/MFLO in EX needs hi/lo
//  hi      out  WIDTH  architectural HI (registered)
//  lo      out  WIDTH  architectural LO (registered)
//  busy    out  1      op in progress (registered)
//  done    out  1      one-cycle pulse: new hi/lo visible this cycle
//  stall   out  1      combinational = busy & (start|mthi|mtlo|mf_req)
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE, hi=lo=0, busy=0, done=0, counter=0; overrides everything incl. mid-op.
//  FSM: IDLE -> RUN (start sampled in IDLE) -> RUN x WIDTH iterations -> FIX (1 cycle) -> IDLE.
//  Accept (IDLE, start=1): latch op; signed ops convert operands to magnitudes, record result signs.
//  RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter 0..WIDTH-1.
//  FIX: apply signs, write hi/lo at the edge ending FIX; done=1 the following cycle only.
//  Timing: start in cycle 0 -> busy=1 cycles 1..WIDTH+1; new hi/lo and done=1 in cycle WIDTH+2 (34).
//  hi/lo hold old values throughout RUN/FIX; never partially updated.
//  MULT/MULTU: {hi,lo} = full 2*WIDTH product (two's complement for MULT).
//  DIV/DIVU: lo = quotient, hi = remainder; DIV truncates toward zero, remainder takes dividend sign.
//  DIV overflow 0x80000000 / -1: lo=0x80000000, hi=0 (wrap, no flag).
//  Divide by zero (rt_val=0, DIV or DIVU): full latency, hi=rs_val (as given), lo=all ones.
//  start/mthi/mtlo while busy: ignored by the unit; stall=1 so upstream holds and re-presents them.
//  mthi/mtlo in IDLE: write at that edge (both may assert together); no stall.
//  start with mthi/mtlo same cycle in IDLE: start wins, moves ignored (decoder never issues this).
//  Done cycle is IDLE: a new start accepted in the same cycle done=1.
//  mf_req while IDLE: stall=0, hi/lo valid; while busy: stall=1 until the done cycle (stall=0 there).
// TESTING
//  MULTU rs=0xFFFFFFFF rt=2, start cycle 0 -> busy cycles 1..33; cycle 34 done=1, hi=0x1, lo=0xFFFFFFFE.
//  MULT rs=-3 rt=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; DIV rs=-7 rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//  DIVU rs=7 rt=0 -> hi=7 lo=0xFFFFFFFF after 34 cycles; DIV 0x80000000/-1 -> lo=0x80000000 hi=0.
//  start+mthi during busy with mf_req held -> stall=1 each busy cycle, hi/lo unchanged, result = first op only.
//  rst asserted cycle 10 of MULT -> cycle 11: busy=0 done=0 hi=lo=0; no later done pulse.
//  mthi=1 rs=0xA5A5A5A5 and mtlo=1 together in IDLE -> next cycle hi=lo=0xA5A5A5A5, stall stays 0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply-divide unit owning architectural HI/LO
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             mf_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dsr_q, dsr_d, hi_q, hi_d, lo_q, lo_d;
  logic div_q, div_d, neg_q, neg_d, negr_q, negr_d, div0_q, div0_d, done_q, done_d;
  logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
  logic [WIDTH:0] mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  always_comb begin
    mag_a = (~op[0] & rs_val[WIDTH-1]) ? -rs_val : rs_val;
    mag_b = (~op[0] & rt_val[WIDTH-1]) ? -rt_val : rt_val;
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dsr_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, dsr_q};
    div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod = neg_q ? -acc_q : acc_q;
    quo = div0_q ? {WIDTH{1'b1}} : neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    dsr_d = dsr_q;
    div_d = div_q;
    neg_d = neg_q;
    negr_d = negr_q;
    div0_d = div0_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = state_q == FIX;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        cnt_d = '0;
        div_d = op[1];
        dsr_d = op[1] ? mag_b : mag_a;
        acc_d = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
        neg_d = ~op[0] & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
        negr_d = ~op[0] & rs_val[WIDTH-1];
        div0_d = rt_val == '0;
      end else begin
        hi_d = mthi ? rs_val : hi_q;
        lo_d = mtlo ? rs_val : lo_q;
      end
    end else if (state_q == RUN) begin
      acc_d = div_q ? div_next : mul_next;
      cnt_d = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : RUN;
    end else begin
      state_d = IDLE;
      {hi_d, lo_d} = div_q ? {rem, quo} : prod;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      dsr_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      negr_q <= 1'b0;
      div0_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      dsr_q <= dsr_d;
      div_q <= div_d;
      neg_q <= neg_d;
      negr_q <= negr_d;
      div0_q <= div0_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
  assign done = done_q;
  assign busy = state_q != IDLE;
  assign stall = busy & (start | mthi | mtlo | mf_req);
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst, start, mthi, mtlo, mf_req;
  logic [1:0] op;
  logic [W-1:0] rs_val, rt_val, hi, lo;
  logic busy, done, stall;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_exp;
  logic [W-1:0] m_hi = '0, m_lo = '0, hold_hi = '0, hold_lo = '0;
  bit rand_mf = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .mthi(mthi), .mtlo(mtlo), .mf_req(mf_req), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .stall(stall)
  );
  function automatic logic [2*W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      2'b00: return 64'(longint'($signed(a)) * longint'($signed(b)));
      2'b01: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b11) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
    endcase
  endfunction
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return 32'($urandom);
    endcase
  endfunction
  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with nothing pending", hi, lo);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({hi, lo} !== mon_exp) begin
          errors++;
          $display("FAIL result: got %h_%h expected %h_%h", hi, lo, mon_exp[2*W-1:W], mon_exp[W-1:0]);
        end
      end
    end
  end
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op = o;
    rs_val = a;
    rt_val = b;
    hold_hi = m_hi;
    hold_lo = m_lo;
    {m_hi, m_lo} = ref_model(o, a, b);
    exp_q.push_back({m_hi, m_lo});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("busy_window", {busy, done, stall, hi, lo},
            {1'b1, 1'b0, start | mthi | mtlo | mf_req, hold_hi, hold_lo});
      @(posedge clk);
      #1;
      if (rand_mf) mf_req = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic finish_op();
    mf_req = 1'b0;
    @(negedge clk);
    check("done_cycle", {busy, done, stall}, 3'b010);
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    launch(o, a, b);
    run_cycles(W + 1);
    finish_op();
  endtask
  initial begin
    int late;
    rst = 1'b1;
    {start, mthi, mtlo, mf_req} = '0;
    op = '0;
    rs_val = '0;
    rt_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {hi, lo, busy, done, stall}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2);
    do_op(2'b00, -32'd3, 32'd5);
    do_op(2'b10, -32'd7, 32'd2);
    do_op(2'b11, 32'd7, 32'd0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(2'b10, -32'd9, 32'd0);
    mthi = 1'b1;
    mtlo = 1'b1;
    mf_req = 1'b1;
    rs_val = 32'hA5A5_A5A5;
    @(negedge clk);
    check("stall_idle", {busy, stall}, 2'b00);
    @(posedge clk);
    #1;
    {mthi, mtlo, mf_req} = '0;
    m_hi = 32'hA5A5_A5A5;
    m_lo = 32'hA5A5_A5A5;
    @(negedge clk);
    check("mthi_mtlo", {hi, lo}, {m_hi, m_lo});
    @(posedge clk);
    #1;
    mthi = 1'b1;
    rs_val = 32'h1234_5678;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    m_hi = 32'h1234_5678;
    @(negedge clk);
    check("mthi_only", {hi, lo}, {m_hi, m_lo});
    @(posedge clk);
    #1;
    launch(2'b00, 32'($urandom), 32'($urandom));
    start = 1'b1;
    op = 2'b11;
    mthi = 1'b1;
    mtlo = 1'b1;
    mf_req = 1'b1;
    rs_val = 32'hDEAD_BEEF;
    run_cycles(W + 1);
    {start, mthi, mtlo} = '0;
    @(negedge clk);
    check("stall_done_cycle", {busy, done, stall}, 3'b010);
    @(posedge clk);
    #1;
    mf_req = 1'b0;
    @(negedge clk);
    check("no_moves_while_busy", {busy, hi, lo}, {1'b0, m_hi, m_lo});
    @(posedge clk);
    #1;
    launch(2'b00, 32'h0001_2345, 32'h0000_6789);
    run_cycles(9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    check("reset_mid_op", {busy, done, hi, lo}, '0);
    late = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) late++;
    end
    check("no_late_done", 72'(late), 72'd0);
    @(posedge clk);
    #1;
    rand_mf = 1;
    for (int k = 0; k < 40; k++) begin
      launch(2'($urandom_range(0, 3)), pick(), pick());
      run_cycles(W + 1);
      if (k == 39 || $urandom_range(0, 1) == 0) finish_op();
    end
    rand_mf = 0;
    mf_req = 1'b0;
    repeat (3) @(posedge clk);
    check("pending_results", 72'(exp_q.size()), 72'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
